// File: rtl/rr_arb_pkg.sv
// Shared constants and state type for the round-robin mux arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr and
// returns the first requester with req high.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from lowest to highest priority so the nearest hit overwrites.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = ptr + SEL_W'(k);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter holding a grant per burst and muxing four data lanes
// onto one valid/ready port. Optional per-grant hold limit: ARB_HOLD_LIMIT_EN.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   in_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          grant,
    output logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready
);

    if (MAX_HOLD == 0) begin : g_max_hold_chk
        $error("MAX_HOLD must be >= 1");
    end

    arb_state_t        r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_grant, w_grant_nxt;
    logic [SEL_W-1:0]  r_sel, w_sel_nxt;
    logic [SEL_W-1:0]  r_ptr, w_ptr_nxt;
    logic              w_busy, w_req_sel, w_xfer, w_release;
    logic              w_found;
    logic [SEL_W-1:0]  w_idx;

    rr_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // Combinational datapath: mux, valid and per-requester strobe.
    assign w_busy    = (r_state == BUSY);
    assign w_req_sel = req[r_sel];
    assign out_valid = w_busy & w_req_sel;
    assign w_xfer    = out_valid & out_ready & ~rst;
    assign ack       = r_grant & {N_REQ{w_xfer}};
    assign out_data  = w_busy ? in_data[r_sel*DATA_W +: DATA_W] : '0;
    assign grant     = r_grant;
    assign sel       = r_sel;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic              w_hold_last, w_others;

    assign w_hold_last = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign w_others    = |(req & ~r_grant);
    assign w_release   = ~w_req_sel | (w_xfer & w_hold_last & w_others);
`else
    assign w_release   = ~w_req_sel;
`endif

    // Next-state: grant on idle, re-arbitrate on release without a bubble.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
`ifdef ARB_HOLD_LIMIT_EN
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        if ((r_state == IDLE) || w_release) begin
            if (w_found) begin
                w_state_nxt    = BUSY;
                w_grant_nxt    = N_REQ'(1) << w_idx;
                w_sel_nxt      = w_idx;
                w_ptr_nxt      = w_idx;
            end else begin
                w_state_nxt    = IDLE;
                w_grant_nxt    = '0;
            end
`ifdef ARB_HOLD_LIMIT_EN
            w_hold_cnt_nxt = '0;
        end else if (w_xfer) begin
            // Limit reached with nobody waiting: keep the grant, restart count.
            w_hold_cnt_nxt = w_hold_last ? '0 : r_hold_cnt + HOLD_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_ptr      <= SEL_W'(N_REQ - 1);
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold_cnt <= w_hold_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter; expectations follow ARB_HOLD_LIMIT_EN.
module tb_rr_mux_arbiter;

    localparam int unsigned DW     = 8;
    localparam int unsigned MH     = 2;
    localparam int unsigned N_XFER = 10;
    localparam int unsigned N_VEC  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          out_ready;
    logic [3:0]    req;
    logic [3:0]    ack;
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [DW-1:0] lane [4];
    logic [4*DW-1:0] in_data;

    assign in_data = {lane[3], lane[2], lane[1], lane[0]};

    always #5 clk = ~clk;

    rr_mux_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .ack       (ack),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [3:0]    req;
        logic [3:0]    grant;
        logic          ov;
        logic [3:0]    ack;
        logic [DW-1:0] data;
    } vec_t;

    typedef struct {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } xfer_t;

    vec_t  tbl [N_VEC];
    xfer_t sb [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    wc [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] one;
        xfer_t      e;
        int         k [4];
        one = 4'b0001;
        for (int i = 0; i < 4; i++) lane[i] = DW'(8'h10 * (i + 1) + i);

`ifdef ARB_HOLD_LIMIT_EN
        tbl[0] = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 8'h10};
        tbl[2] = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 8'h10};
        tbl[3] = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 8'h32};
        tbl[4] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 8'h32};
        tbl[5] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 8'h32};
        tbl[6] = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 8'h32};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00};
`else
        tbl[0] = '{4'b0101, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[1] = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 8'h10};
        tbl[2] = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 8'h10};
        tbl[3] = '{4'b0101, 4'b0001, 1'b1, 4'b0001, 8'h10};
        tbl[4] = '{4'b0100, 4'b0001, 1'b0, 4'b0000, 8'h10};
        tbl[5] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 8'h32};
        tbl[6] = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 8'h32};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h00};
`endif

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_grant", grant, 4'b0000);
        chk("reset_sel", sel, 2'd0);
        chk("reset_ack", ack, 4'b0000);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        next_cycle();

        // Table-driven basic arbitration and mux
        for (int i = 0; i < N_VEC; i++) begin
            req = tbl[i].req;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].data);
            if (tbl[i].grant != 4'b0000)
                chk($sformatf("vec%0d_sel", i), sel, oh2idx(tbl[i].grant));
            next_cycle();
        end

        // Rotation with all requesters pending: scoreboard of (requester, word)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wc[i] = 0;
            k[i]  = 0;
        end
        for (int t = 0; t < N_XFER; t++) begin
`ifdef ARB_HOLD_LIMIT_EN
            e.idx = 2'((t / MH) % 4);
`else
            e.idx = 2'd0;
`endif
            e.data = {e.idx, 6'(k[e.idx])};
            k[e.idx]++;
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) lane[i] = {2'(i), 6'(wc[i])};
        req = 4'b1111;
        @(negedge clk);
        chk("rot_latency_ack", ack, 4'b0000);
        next_cycle();
        for (int c = 0; c < N_XFER; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("rot_sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rot%0d_ack", c), ack, one << e.idx);
                chk($sformatf("rot%0d_data", c), out_data, e.data);
            end
            for (int i = 0; i < 4; i++) if (ack[i]) wc[i]++;
            next_cycle();
            for (int i = 0; i < 4; i++) lane[i] = {2'(i), 6'(wc[i])};
        end
        chk("rot_sb_empty", 32'(sb.size()), 32'd0);

        // Lone requester 2 keeps its grant across the hold limit
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        chk("solo_latency_grant", grant, 4'b0000);
        next_cycle();
        for (int c = 0; c < 3 * MH; c++) begin
            @(negedge clk);
            chk($sformatf("solo%0d_grant", c), grant, 4'b0100);
            chk($sformatf("solo%0d_ack", c), ack, 4'b0100);
            next_cycle();
        end

        // Downstream stall mid-burst on lane 1
        do_reset();
        lane[1] = 8'hA5;
        req     = 4'b0010;
        next_cycle();
        @(negedge clk);
        chk("stall_pre_ack", ack, 4'b0010);
        next_cycle();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
            chk($sformatf("stall%0d_out_data", c), out_data, 8'hA5);
            chk($sformatf("stall%0d_ack", c), ack, 4'b0000);
            chk($sformatf("stall%0d_grant", c), grant, 4'b0010);
            next_cycle();
        end
        out_ready = 1'b1;

        // Reset pulsed while requester 3 holds the grant
        do_reset();
        req = 4'b1000;
        next_cycle();
        @(negedge clk);
        chk("rst_pre_grant", grant, 4'b1000);
        next_cycle();
        rst = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        chk("rst_ack_gated", ack, 4'b0000);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_post_grant", grant, 4'b0000);
        chk("rst_post_sel", sel, 2'd0);
        chk("rst_post_ack", ack, 4'b0000);
        next_cycle();
        @(negedge clk);
        chk("rst_regrant", grant, 4'b0001);
        chk("rst_regrant_sel", sel, 2'd0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
